muldiv_sequencer: RTL and testbench
===================================

# muldiv_sequencer

Iterative multiply/divide sequencer that owns the HI/LO register pair for MULT, MULTU, DIV and DIVU. It sits beside the ArithmeticLogicUnit in the execute stage. The decoder issues a one-cycle start, and the pipeline stalls while busy is high. At completion it writes a 64-bit result into HI/LO, where MFHI/MFLO read it and MTHI/MTLO write it. It replaces single-cycle combinational `*` and `/` with a fixed-latency radix-2 datapath.

## Interface
- WIDTH, 32, operand width; HI and LO are each WIDTH bits
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high; one clock domain, reset sampled only on the rising edge of clock
- start  input  1  request a new operation; sampled only in IDLE
- op_div  input  1  0 = multiply, 1 = divide
- signed_op  input  1  1 = signed operation (MULT/DIV)
- read_data_1  input  WIDTH  multiplicand / dividend
- read_data_2  input  WIDTH  multiplier / divisor
- hi_we, lo_we  input  1  MTHI / MTLO write enables
- write_data  input  WIDTH  data for MTHI/MTLO
- hi, lo  output  WIDTH  architectural HI/LO registers
- busy  output  1  operation in flight; pipeline stall request
- done  output  1  one-cycle completion pulse
- div_by_zero  output  1  last completed divide had a zero divisor; held until the next start is accepted

## Operation
- State IDLE:
  - Start accepted: latch the operand magnitudes and record the result signs, which are computed only when signed_op is set and the macro is enabled.
  - Clear div_by_zero and count.
  - Go to CALC, or go directly to FINISH if op_div=1 and read_data_2=0.
- State CALC: one iteration per cycle; count runs 0..WIDTH-1.
  - Multiply: shift-add into a 2·WIDTH accumulator.
  - Divide: restoring shift-subtract, producing the quotient and a partial remainder.
  - At count=WIDTH-1, go to FINISH.
- State FINISH, then IDLE:
  - Apply sign correction (two's-complement negate).
  - Write hi/lo, pulse done, and return to IDLE.
- Results:
  - Multiply: {hi,lo} = full 2·WIDTH product.
  - Divide: lo = quotient, hi = remainder.
  - Signed quotient truncates toward zero; the remainder takes the sign of the dividend.
  - Signed -2^31 / -1 gives lo=0x80000000, hi=0, with no flag.
- Divide by zero: hi = dividend unchanged, lo = all ones, div_by_zero=1.
- MTHI/MTLO:
  - Write hi/lo at the edge, only in IDLE.
  - Ignored while busy.
  - If start and a write occur in the same cycle, start wins and the write is dropped.
- A start while busy is ignored. The decoder must hold the stall, not re-issue the start.

## Timing
- Reset values:
  - Outputs: hi=0, lo=0, busy=0, done=0, div_by_zero=0.
  - Internal state: state=IDLE, count=0.
- Reset in the middle of an operation aborts it: no done pulse, and HI/LO are cleared.
- Start accepted at edge N:
  - busy is high after edge N.
  - Iterations occur at edges N+1..N+WIDTH.
  - At edge N+WIDTH+1, hi/lo update, done=1, and busy=0.
  - Latency is WIDTH+1 cycles (33 for WIDTH=32).
- Divide by zero: at edge N+1, hi/lo update and done=1 (latency 1).
- done is high for exactly one cycle. In that same cycle the state is IDLE, so a new start is accepted with no bubble.
- hi/lo hold their old values until the FINISH edge, so MFHI during busy returns the old value. The pipeline is responsible for stalling MFHI/MFLO until done.
- MTHI/MTLO have one-edge latency.

## Configuration
- MULDIV_SIGNED_EN defined:
  - signed_op is honoured.
  - Implements operand magnitude/sign capture and result negation in FINISH.
- MULDIV_SIGNED_EN undefined:
  - signed_op is ignored and every operation is unsigned.
  - The sign logic is compiled out.
  - FINISH remains, so latency is unchanged.

## Test plan
- Reset, then MULTU 0xFFFFFFFF × 0xFFFFFFFF -> busy for 33 cycles, then done pulse; hi=0xFFFFFFFE, lo=0x00000001.
- DIVU 100 / 7 -> after 33 cycles, lo=14, hi=2, div_by_zero=0; a second start pulse during busy is ignored.
- With MULDIV_SIGNED_EN: DIV -7 / 2 gives lo=0xFFFFFFFD, hi=0xFFFFFFFF; MULT -3 × 5 gives {hi,lo}=0xFFFFFFFF_FFFFFFF1. Without the macro, MULT 0xFFFFFFFD × 5 gives hi=4, lo=0xFFFFFFF1.
- DIVU 0x1234 / 0 -> done one cycle after start; hi=0x1234, lo=0xFFFFFFFF, div_by_zero=1; the flag clears on the next accepted start.
- MTHI 0xA5A5A5A5 while idle -> hi updates next edge. MTLO while busy -> lo unchanged. Start plus MTLO in the same cycle -> the operation runs and the write is dropped.
- Reset asserted at iteration 10 of a MULTU -> hi=lo=0, busy=0, no done pulse. Start in the done cycle -> accepted, back-to-back result after 33 further cycles.

Source files
------------

// File: rtl/muldiv_sequencer_if.sv
// muldiv_sequencer_if: decoder-side request bundle and HI/LO result view
// for the iterative multiply/divide sequencer.
interface muldiv_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             op_div;
    logic             signed_op;
    logic [WIDTH-1:0] read_data_1;
    logic [WIDTH-1:0] read_data_2;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] write_data;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             div_by_zero;

    modport master (
        output start,
        output op_div,
        output signed_op,
        output read_data_1,
        output read_data_2,
        output hi_we,
        output lo_we,
        output write_data,
        input  hi,
        input  lo,
        input  busy,
        input  done,
        input  div_by_zero
    );

    modport slave (
        input  start,
        input  op_div,
        input  signed_op,
        input  read_data_1,
        input  read_data_2,
        input  hi_we,
        input  lo_we,
        input  write_data,
        output hi,
        output lo,
        output busy,
        output done,
        output div_by_zero
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: radix-2 iterative MULT/MULTU/DIV/DIVU owning HI/LO.
// Define MULDIV_SIGNED_EN to honour signed_op; otherwise every op is unsigned.
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input logic               clock,
    input logic               reset,
    muldiv_sequencer_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FINISH
    } state_t;

    state_t state;
    state_t state_next;

    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;
    logic               is_div;
    logic               dbz;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               done_q;
    logic               dbz_flag;

    logic               accept;
    logic               zero_div;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic               sign_a;
    logic               sign_b;

    assign accept   = (state == IDLE) && bus.start;
    assign zero_div = bus.op_div && (bus.read_data_2 == '0);

`ifdef MULDIV_SIGNED_EN
    logic neg_res;
    logic neg_rem;

    assign sign_a = bus.signed_op && bus.read_data_1[WIDTH-1];
    assign sign_b = bus.signed_op && bus.read_data_2[WIDTH-1];
    assign mag_a  = sign_a ? -bus.read_data_1 : bus.read_data_1;
    assign mag_b  = sign_b ? -bus.read_data_2 : bus.read_data_2;
`else
    logic unused_signed_op;

    assign unused_signed_op = bus.signed_op;
    assign sign_a = 1'b0;
    assign sign_b = 1'b0;
    assign mag_a  = bus.read_data_1;
    assign mag_b  = bus.read_data_2;
`endif

    // Multiply step: add multiplicand into the upper half when the
    // current multiplier bit (acc[0]) is set, then shift right.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;

    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]}
                    + (acc[0] ? {1'b0, opnd} : '0);
    assign mul_next = {mul_sum, acc[WIDTH-1:1]};

    // Divide step: upper half is the partial remainder, lower half
    // shifts the dividend out and the quotient bits in.
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] div_next;

    assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign div_trial = div_shift - {1'b0, opnd};

    always_comb begin
        div_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        if (!div_trial[WIDTH]) begin
            div_next = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end
    end

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;

    always_comb begin
        prod = acc;
        quo  = acc[WIDTH-1:0];
        rem  = acc[2*WIDTH-1:WIDTH];
`ifdef MULDIV_SIGNED_EN
        if (neg_res) begin
            prod = -acc;
            quo  = -acc[WIDTH-1:0];
        end
        if (neg_rem) begin
            rem = -acc[2*WIDTH-1:WIDTH];
        end
`endif
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = zero_div ? FINISH : CALC;
                end
            end
            CALC: begin
                if (count == CW'(WIDTH - 1)) begin
                    state_next = FINISH;
                end
            end
            FINISH: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count    <= '0;
            acc      <= '0;
            opnd     <= '0;
            is_div   <= 1'b0;
            dbz      <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            dbz_flag <= 1'b0;
`ifdef MULDIV_SIGNED_EN
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
`endif
        end else begin
            done_q <= (state == FINISH);
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        count    <= '0;
                        dbz_flag <= 1'b0;
                        is_div   <= bus.op_div;
                        dbz      <= zero_div;
`ifdef MULDIV_SIGNED_EN
                        neg_res  <= sign_a ^ sign_b;
                        neg_rem  <= bus.op_div && sign_a;
`endif
                        if (zero_div) begin
                            acc  <= {{WIDTH{1'b0}}, bus.read_data_1};
                            opnd <= '0;
                        end else if (bus.op_div) begin
                            acc  <= {{WIDTH{1'b0}}, mag_a};
                            opnd <= mag_b;
                        end else begin
                            acc  <= {{WIDTH{1'b0}}, mag_b};
                            opnd <= mag_a;
                        end
                    end else begin
                        if (bus.hi_we) begin
                            hi_q <= bus.write_data;
                        end
                        if (bus.lo_we) begin
                            lo_q <= bus.write_data;
                        end
                    end
                end
                CALC: begin
                    acc   <= is_div ? div_next : mul_next;
                    count <= count + CW'(1);
                end
                FINISH: begin
                    if (dbz) begin
                        hi_q     <= acc[WIDTH-1:0];
                        lo_q     <= '1;
                        dbz_flag <= 1'b1;
                    end else if (is_div) begin
                        hi_q <= rem;
                        lo_q <= quo;
                    end else begin
                        {hi_q, lo_q} <= prod;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
    assign bus.busy        = (state != IDLE);
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_flag;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: randomized and directed checks of the multiply/
// divide sequencer against an arithmetic reference model.
module tb_muldiv_sequencer;
    localparam int W = 32;
`ifdef MULDIV_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    int tests = 0;
    int fails = 0;

    muldiv_sequencer_if #(.WIDTH(W)) bus();

    muldiv_sequencer #(.WIDTH(W)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    // Returns {div_by_zero, hi, lo}.
    function automatic logic [64:0] model(input bit div, input bit sg,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        bit s;
        s = sg && SIGNED_EN;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (!div) begin
            if (s) p = sa * sb;
            else p = {32'b0, a} * {32'b0, b};
            return {1'b0, p};
        end
        if (b == 32'h0) return {1'b1, a, 32'hFFFF_FFFF};
        if (s) begin
            q = sa / sb;
            r = sa % sb;
        end else begin
            q = longint'({32'b0, a}) / longint'({32'b0, b});
            r = longint'({32'b0, a}) % longint'({32'b0, b});
        end
        return {1'b0, r[31:0], q[31:0]};
    endfunction

    task automatic pulse_start(input bit div, input bit sg,
                               input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.op_div = div;
        bus.signed_op = sg;
        bus.read_data_1 = a;
        bus.read_data_2 = b;
        @(negedge clock);
        bus.start = 1'b0;
    endtask

    task automatic start_op(input bit div, input bit sg,
                            input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        pulse_start(div, sg, a, b);
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < 100) begin
            @(negedge clock);
            cyc++;
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [67:0] got;
        do_reset();
        got = {bus.hi, bus.lo, bus.busy, bus.done, bus.div_by_zero, 1'b0};
        tests++;
        if (got !== 68'h0) begin
            fails++;
            $display("FAIL reset_state got=%h want=0", got);
        end
    endtask

    task automatic test_multu_max();
        int cyc;
        start_op(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        tests++;
        if (bus.busy !== 1'b1) begin
            fails++;
            $display("FAIL multu_busy got=%b want=1", bus.busy);
        end
        wait_done(cyc);
        tests++;
        if (cyc != 33) begin
            fails++;
            $display("FAIL multu_latency got=%0d want=33", cyc);
        end
        tests++;
        if ({bus.hi, bus.lo} !== 64'hFFFF_FFFE_0000_0001 || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL multu_result got=%h_%h busy=%b", bus.hi, bus.lo, bus.busy);
        end
        @(negedge clock);
        tests++;
        if (bus.done !== 1'b0) begin
            fails++;
            $display("FAIL done_width got=%b want=0", bus.done);
        end
    endtask

    task automatic test_divu_restart();
        int cyc;
        start_op(1'b1, 1'b0, 32'd100, 32'd7);
        repeat (4) @(negedge clock);
        pulse_start(1'b0, 1'b0, 32'd3, 32'd3);
        wait_done(cyc);
        cyc += 5;
        tests++;
        if (cyc != 33) begin
            fails++;
            $display("FAIL divu_latency got=%0d want=33", cyc);
        end
        tests++;
        if ({bus.div_by_zero, bus.hi, bus.lo} !== {1'b0, 32'd2, 32'd14}) begin
            fails++;
            $display("FAIL divu_result got=%b %h %h want=0 2 14",
                     bus.div_by_zero, bus.hi, bus.lo);
        end
        repeat (3) @(negedge clock);
        tests++;
        if (bus.busy !== 1'b0 || bus.lo !== 32'd14) begin
            fails++;
            $display("FAIL restart_ignored busy=%b lo=%h", bus.busy, bus.lo);
        end
    endtask

    task automatic test_signed();
        int cyc;
        logic [63:0] exp;
        start_op(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2);
        wait_done(cyc);
        exp = SIGNED_EN ? 64'hFFFF_FFFF_FFFF_FFFD : 64'h0000_0001_7FFF_FFFC;
        tests++;
        if ({bus.hi, bus.lo} !== exp) begin
            fails++;
            $display("FAIL div_neg7_2 got=%h_%h want=%h", bus.hi, bus.lo, exp);
        end
        start_op(1'b0, 1'b1, 32'hFFFF_FFFD, 32'd5);
        wait_done(cyc);
        exp = SIGNED_EN ? 64'hFFFF_FFFF_FFFF_FFF1 : 64'h0000_0004_FFFF_FFF1;
        tests++;
        if ({bus.hi, bus.lo} !== exp) begin
            fails++;
            $display("FAIL mult_neg3_5 got=%h_%h want=%h", bus.hi, bus.lo, exp);
        end
        start_op(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(cyc);
        exp = SIGNED_EN ? 64'h0000_0000_8000_0000 : 64'h8000_0000_0000_0000;
        tests++;
        if ({bus.div_by_zero, bus.hi, bus.lo} !== {1'b0, exp}) begin
            fails++;
            $display("FAIL div_overflow got=%b %h_%h want=0 %h",
                     bus.div_by_zero, bus.hi, bus.lo, exp);
        end
    endtask

    task automatic test_div_zero();
        int cyc;
        start_op(1'b1, 1'b0, 32'h1234, 32'h0);
        wait_done(cyc);
        tests++;
        if (cyc != 1) begin
            fails++;
            $display("FAIL dbz_latency got=%0d want=1", cyc);
        end
        tests++;
        if ({bus.div_by_zero, bus.hi, bus.lo} !== {1'b1, 32'h1234, 32'hFFFF_FFFF}) begin
            fails++;
            $display("FAIL dbz_result got=%b %h %h want=1 1234 ffffffff",
                     bus.div_by_zero, bus.hi, bus.lo);
        end
        repeat (2) @(negedge clock);
        tests++;
        if (bus.div_by_zero !== 1'b1) begin
            fails++;
            $display("FAIL dbz_held got=%b want=1", bus.div_by_zero);
        end
        start_op(1'b0, 1'b0, 32'd2, 32'd3);
        tests++;
        if (bus.div_by_zero !== 1'b0) begin
            fails++;
            $display("FAIL dbz_clear got=%b want=0", bus.div_by_zero);
        end
        wait_done(cyc);
    endtask

    task automatic test_mt();
        int cyc;
        @(negedge clock);
        bus.hi_we = 1'b1;
        bus.write_data = 32'hA5A5_A5A5;
        @(negedge clock);
        bus.hi_we = 1'b0;
        tests++;
        if (bus.hi !== 32'hA5A5_A5A5) begin
            fails++;
            $display("FAIL mthi got=%h want=a5a5a5a5", bus.hi);
        end
        bus.lo_we = 1'b1;
        bus.write_data = 32'h1111_1111;
        @(negedge clock);
        bus.lo_we = 1'b0;
        start_op(1'b0, 1'b0, 32'd6, 32'd7);
        bus.lo_we = 1'b1;
        bus.write_data = 32'hDEAD_BEEF;
        @(negedge clock);
        bus.lo_we = 1'b0;
        tests++;
        if (bus.lo !== 32'h1111_1111) begin
            fails++;
            $display("FAIL mtlo_busy got=%h want=11111111", bus.lo);
        end
        wait_done(cyc);
        tests++;
        if ({bus.hi, bus.lo} !== 64'd42) begin
            fails++;
            $display("FAIL mul_after_mt got=%h_%h want=42", bus.hi, bus.lo);
        end
        @(negedge clock);
        bus.lo_we = 1'b1;
        bus.write_data = 32'hCAFE_0000;
        pulse_start(1'b1, 1'b0, 32'd50, 32'd5);
        bus.lo_we = 1'b0;
        tests++;
        if (bus.lo !== 32'd42 || bus.busy !== 1'b1) begin
            fails++;
            $display("FAIL start_mtlo got lo=%h busy=%b want lo=2a busy=1",
                     bus.lo, bus.busy);
        end
        wait_done(cyc);
        tests++;
        if ({bus.hi, bus.lo} !== {32'd0, 32'd10}) begin
            fails++;
            $display("FAIL start_mtlo_result got=%h_%h want=0_a", bus.hi, bus.lo);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        start_op(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (10) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        tests++;
        if ({bus.hi, bus.lo, bus.busy, bus.done} !== 66'h0) begin
            fails++;
            $display("FAIL reset_mid got hi=%h lo=%h busy=%b done=%b",
                     bus.hi, bus.lo, bus.busy, bus.done);
        end
        seen = 0;
        repeat (40) begin
            @(negedge clock);
            if (bus.done === 1'b1) seen++;
        end
        tests++;
        if (seen != 0) begin
            fails++;
            $display("FAIL reset_no_done got=%0d want=0", seen);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        start_op(1'b0, 1'b0, 32'd1000, 32'd1000);
        wait_done(cyc);
        pulse_start(1'b1, 1'b0, 32'd1000, 32'd33);
        tests++;
        if (bus.busy !== 1'b1 || {bus.hi, bus.lo} !== 64'd1000000) begin
            fails++;
            $display("FAIL b2b_accept busy=%b got=%h_%h", bus.busy, bus.hi, bus.lo);
        end
        wait_done(cyc);
        tests++;
        if (cyc != 33 || {bus.hi, bus.lo} !== {32'd10, 32'd30}) begin
            fails++;
            $display("FAIL b2b_result cyc=%0d got=%h_%h want 33 a_1e",
                     cyc, bus.hi, bus.lo);
        end
    endtask

    task automatic test_random();
        int cyc;
        int want_cyc;
        bit div;
        bit sg;
        logic [31:0] a;
        logic [31:0] b;
        logic [64:0] exp;
        for (int i = 0; i < 60; i++) begin
            div = 1'($urandom_range(0, 1));
            sg = 1'($urandom_range(0, 1));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'h0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 20));
                3: b = -32'($urandom_range(1, 20));
                default: ;
            endcase
            exp = model(div, sg, a, b);
            want_cyc = (div && b == 32'h0) ? 1 : 33;
            start_op(div, sg, a, b);
            wait_done(cyc);
            tests++;
            if (cyc != want_cyc ||
                {bus.div_by_zero, bus.hi, bus.lo} !== exp) begin
                fails++;
                $display("FAIL rand%0d div=%b sg=%b a=%h b=%h cyc=%0d got=%b_%h_%h want=%0d %h",
                         i, div, sg, a, b, cyc, bus.div_by_zero, bus.hi,
                         bus.lo, want_cyc, exp);
            end
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.op_div = 1'b0;
        bus.signed_op = 1'b0;
        bus.read_data_1 = '0;
        bus.read_data_2 = '0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        bus.write_data = '0;
        test_reset();
        test_multu_max();
        test_divu_restart();
        test_signed();
        test_div_zero();
        test_mt();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
